// File: rtl/valu_rr_sched_if.sv
// valu_rr_sched_if: requester, ALU and control signals of the shared vector-ALU scheduler
interface valu_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int VECTOR_WIDTH = 64,
  parameter int VECTOR_BYTE = 8,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*VECTOR_WIDTH-1:0] req_vec1;
  logic [NUM_REQ*VECTOR_WIDTH-1:0] req_vec2;
  logic [NUM_REQ*VECTOR_BYTE-1:0] req_byte_en;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic alu_valid;
  logic [VECTOR_WIDTH-1:0] alu_vec1;
  logic [VECTOR_WIDTH-1:0] alu_vec2;
  logic [VECTOR_BYTE-1:0] alu_byte_en;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [VECTOR_WIDTH-1:0] alu_out_vec;
  logic [ADDR_WIDTH-1:0] alu_out_addr;
  logic [NUM_REQ-1:0] resp_valid;
  logic [VECTOR_WIDTH-1:0] resp_vec;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic flush_req;
  logic flush_done;
  logic [NUM_REQ*16-1:0] grant_cnt;
  logic stats_clr;
  modport master (
    output req_valid, req_vec1, req_vec2, req_byte_en, req_addr, alu_out_vec, alu_out_addr, flush_req, stats_clr,
    input req_ready, alu_valid, alu_vec1, alu_vec2, alu_byte_en, alu_addr, resp_valid, resp_vec, resp_addr, flush_done, grant_cnt
  );
  modport slave (
    input req_valid, req_vec1, req_vec2, req_byte_en, req_addr, alu_out_vec, alu_out_addr, flush_req, stats_clr,
    output req_ready, alu_valid, alu_vec1, alu_vec2, alu_byte_en, alu_addr, resp_valid, resp_vec, resp_addr, flush_done, grant_cnt
  );
endinterface

// File: rtl/valu_rr_sched.sv
// valu_rr_sched: round-robin sharing of one fixed-latency vector ALU with tag-tracked responses and a flush/drain FSM
// Optional per-requester grant counters are built when VALU_SCHED_STATS_EN is defined.
module valu_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int VECTOR_WIDTH = 64,
  parameter int VECTOR_BYTE = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int ALU_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  valu_rr_sched_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state_q;
  logic flush_done_q;
  logic gnt_any, hs, drained;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] issue_id_q, issue_id_d;
  logic alu_valid_q, alu_valid_d;
  logic [VECTOR_WIDTH-1:0] alu_vec1_q, alu_vec1_d, alu_vec2_q, alu_vec2_d;
  logic [VECTOR_BYTE-1:0] alu_byte_en_q, alu_byte_en_d;
  logic [ADDR_WIDTH-1:0] alu_addr_q, alu_addr_d;
  logic [ALU_LATENCY-1:0] tag_v_q, tag_v_d;
  logic [IW-1:0] tag_id_q [ALU_LATENCY];
  logic [IW-1:0] tag_id_d [ALU_LATENCY];
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [VECTOR_WIDTH-1:0] resp_vec_q, resp_vec_d;
  logic [ADDR_WIDTH-1:0] resp_addr_q, resp_addr_d;
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    return IW'((int'(a) + b) % NUM_REQ);
  endfunction
  // first valid requester at or after the pointer, wrapping; lower search offsets override higher ones
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_add(ptr_q, k)]) begin
        gnt_any = 1'b1;
        gnt_id = wrap_add(ptr_q, k);
      end
    end
  end
  // grants only while staying in RUN, so a flush request blocks the same-cycle grant
  assign hs = gnt_any && state_q == RUN && !bus.flush_req && !rst;
  assign bus.req_ready = hs ? NUM_REQ'(1) << gnt_id : '0;
  assign drained = !alu_valid_q && !(|tag_v_q) && !(|resp_valid_q);
  // next-state of pointer, issue registers, tag pipe and response registers
  always_comb begin
    ptr_d = hs ? wrap_add(gnt_id, 1) : ptr_q;
    alu_valid_d = hs;
    issue_id_d = hs ? gnt_id : issue_id_q;
    alu_vec1_d = hs ? bus.req_vec1[gnt_id*VECTOR_WIDTH +: VECTOR_WIDTH] : alu_vec1_q;
    alu_vec2_d = hs ? bus.req_vec2[gnt_id*VECTOR_WIDTH +: VECTOR_WIDTH] : alu_vec2_q;
    alu_byte_en_d = hs ? bus.req_byte_en[gnt_id*VECTOR_BYTE +: VECTOR_BYTE] : alu_byte_en_q;
    alu_addr_d = hs ? bus.req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH] : alu_addr_q;
    tag_v_d = tag_v_q;
    tag_id_d = tag_id_q;
    tag_v_d[0] = alu_valid_q && alu_byte_en_q[0];
    tag_id_d[0] = issue_id_q;
    for (int j = 1; j < ALU_LATENCY; j++) begin
      tag_v_d[j] = tag_v_q[j-1];
      tag_id_d[j] = tag_id_q[j-1];
    end
    resp_valid_d = tag_v_q[ALU_LATENCY-1] ? NUM_REQ'(1) << tag_id_q[ALU_LATENCY-1] : '0;
    resp_vec_d = tag_v_q[ALU_LATENCY-1] ? bus.alu_out_vec : resp_vec_q;
    resp_addr_d = tag_v_q[ALU_LATENCY-1] ? bus.alu_out_addr : resp_addr_q;
  end
  // datapath state; reset discards every in-flight tag
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      issue_id_q <= '0;
      alu_valid_q <= 1'b0;
      alu_vec1_q <= '0;
      alu_vec2_q <= '0;
      alu_byte_en_q <= '0;
      alu_addr_q <= '0;
      tag_v_q <= '0;
      tag_id_q <= '{default: '0};
      resp_valid_q <= '0;
      resp_vec_q <= '0;
      resp_addr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      issue_id_q <= issue_id_d;
      alu_valid_q <= alu_valid_d;
      alu_vec1_q <= alu_vec1_d;
      alu_vec2_q <= alu_vec2_d;
      alu_byte_en_q <= alu_byte_en_d;
      alu_addr_q <= alu_addr_d;
      tag_v_q <= tag_v_d;
      tag_id_q <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_vec_q <= resp_vec_d;
      resp_addr_q <= resp_addr_d;
    end
  end
  // flush FSM: RUN -> DRAIN until nothing is in flight -> DONE for one pulse -> RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= state_q == DRAIN && drained;
      state_q <= state_q == RUN ? (bus.flush_req ? DRAIN : RUN) :
                 state_q == DRAIN ? (drained ? DONE : DRAIN) : RUN;
    end
  end
  assign bus.alu_valid = alu_valid_q;
  assign bus.alu_vec1 = alu_vec1_q;
  assign bus.alu_vec2 = alu_vec2_q;
  assign bus.alu_byte_en = alu_byte_en_q;
  assign bus.alu_addr = alu_addr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_vec = resp_vec_q;
  assign bus.resp_addr = resp_addr_q;
  assign bus.flush_done = flush_done_q;
`ifdef VALU_SCHED_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];
  // saturating grant counters; clear takes priority over a same-cycle grant
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      cnt_d[i] = bus.stats_clr ? 16'd0 : (hs && gnt_id == IW'(i) && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1 : cnt_q[i];
  end
  // counter state
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  end
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign bus.grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`else
  logic unused_stats;
  assign unused_stats = bus.stats_clr;
  assign bus.grant_cnt = '0;
`endif
endmodule

// File: tb/tb_valu_rr_sched.sv
// tb_valu_rr_sched: directed scoreboard bench for the round-robin vector-ALU scheduler
module tb_valu_rr_sched;
  logic clk;
  logic rst;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  typedef struct {
    int id;
    logic [63:0] vec;
    logic [31:0] addr;
    int due;
  } exp_t;
  exp_t sb[$];
  exp_t me;
`ifdef VALU_SCHED_STATS_EN
  localparam logic [63:0] EXP_CNT = 64'd3;
`else
  localparam logic [63:0] EXP_CNT = 64'd0;
`endif
  valu_rr_sched_if bus ();
  valu_rr_sched dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  // single-cycle vector-add ALU model
  always @(posedge clk) begin
    if (bus.alu_valid) begin
      bus.alu_out_vec <= bus.alu_vec1 + bus.alu_vec2;
      bus.alu_out_addr <= bus.alu_addr;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // every response is matched against the oldest expected result
  always @(negedge clk) begin
    if (bus.resp_valid !== 4'b0000) begin
      if (sb.size() == 0) chk("resp_spurious", 64'(bus.resp_valid), 64'd0);
      else begin
        me = sb.pop_front();
        chk("resp_id", 64'(bus.resp_valid), 64'd1 << me.id);
        chk("resp_vec", bus.resp_vec, me.vec);
        chk("resp_addr", 64'(bus.resp_addr), 64'(me.addr));
        chk("resp_cycle", 64'(cyc), 64'(me.due));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [63:0] v1, input logic [63:0] v2, input logic [7:0] be, input logic [31:0] a);
    bus.req_vec1[i*64 +: 64] = v1;
    bus.req_vec2[i*64 +: 64] = v2;
    bus.req_byte_en[i*8 +: 8] = be;
    bus.req_addr[i*32 +: 32] = a;
  endtask
  task automatic cyc_check(input logic [3:0] rdy, input logic fd, input logic push);
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), 64'(rdy));
    chk("flush_done", 64'(bus.flush_done), 64'(fd));
    for (int i = 0; i < 4; i++)
      if (rdy[i] && push && bus.req_byte_en[i*8])
        sb.push_back('{i, bus.req_vec1[i*64 +: 64] + bus.req_vec2[i*64 +: 64], bus.req_addr[i*32 +: 32], cyc + 3});
    tick();
  endtask
  task automatic idle(input int n);
    repeat (n) cyc_check(4'b0000, 1'b0, 1'b0);
  endtask
  task automatic chk_zero_outs();
    @(negedge clk);
    chk("z_req_ready", 64'(bus.req_ready), 64'd0);
    chk("z_alu_valid", 64'(bus.alu_valid), 64'd0);
    chk("z_alu_vec1", bus.alu_vec1, 64'd0);
    chk("z_alu_vec2", bus.alu_vec2, 64'd0);
    chk("z_alu_byte_en", 64'(bus.alu_byte_en), 64'd0);
    chk("z_alu_addr", 64'(bus.alu_addr), 64'd0);
    chk("z_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("z_resp_vec", bus.resp_vec, 64'd0);
    chk("z_resp_addr", 64'(bus.resp_addr), 64'd0);
    chk("z_flush_done", 64'(bus.flush_done), 64'd0);
    chk("z_grant_cnt", bus.grant_cnt, 64'd0);
    tick();
  endtask
  initial begin
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_vec1 = '0;
    bus.req_vec2 = '0;
    bus.req_byte_en = '0;
    bus.req_addr = '0;
    bus.flush_req = 1'b0;
    bus.stats_clr = 1'b0;
    tick();
    tick();
    chk_zero_outs();
    rst = 1'b0;
    bus.req_valid = 4'b0000;
    tick();
    set_req(2, 64'd5, 64'd7, 8'hFF, 32'h40);
    bus.req_valid = 4'b0100;
    cyc_check(4'b0100, 1'b0, 1'b1);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("issue_valid", 64'(bus.alu_valid), 64'd1);
    chk("issue_vec1", bus.alu_vec1, 64'd5);
    chk("issue_vec2", bus.alu_vec2, 64'd7);
    chk("issue_addr", 64'(bus.alu_addr), 64'h40);
    tick();
    idle(3);
    set_req(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 8'hFF, 32'h100);
    set_req(0, 64'h1234, 64'h1111, 8'h0F, 32'h200);
    bus.req_valid = 4'b1001;
    cyc_check(4'b1000, 1'b0, 1'b1);
    bus.req_valid = 4'b0001;
    cyc_check(4'b0001, 1'b0, 1'b1);
    bus.req_valid = 4'b0000;
    idle(4);
    set_req(1, 64'd9, 64'd9, 8'hFE, 32'h300);
    bus.req_valid = 4'b0010;
    cyc_check(4'b0010, 1'b0, 1'b1);
    bus.req_valid = 4'b0000;
    idle(5);
    set_req(2, 64'd3, 64'd4, 8'hFF, 32'h44);
    bus.req_valid = 4'b0100;
    cyc_check(4'b0100, 1'b0, 1'b0);
    bus.req_valid = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero_outs();
    idle(5);
    for (int i = 0; i < 4; i++) set_req(i, 64'(i + 1), 64'(10 * (i + 1)), 8'hFF, 32'h1000 + 32'(i));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) cyc_check(4'b0001 << (k % 4), 1'b0, 1'b1);
    bus.req_valid = 4'b0000;
    idle(4);
    bus.req_valid = 4'b0011;
    cyc_check(4'b0001, 1'b0, 1'b1);
    cyc_check(4'b0010, 1'b0, 1'b1);
    bus.flush_req = 1'b1;
    cyc_check(4'b0000, 1'b0, 1'b1);
    bus.flush_req = 1'b0;
    repeat (3) cyc_check(4'b0000, 1'b0, 1'b1);
    cyc_check(4'b0000, 1'b1, 1'b1);
    cyc_check(4'b0001, 1'b0, 1'b1);
    bus.req_valid = 4'b0000;
    idle(4);
    bus.flush_req = 1'b1;
    cyc_check(4'b0000, 1'b0, 1'b0);
    bus.flush_req = 1'b0;
    cyc_check(4'b0000, 1'b0, 1'b0);
    cyc_check(4'b0000, 1'b1, 1'b0);
    cyc_check(4'b0000, 1'b0, 1'b0);
    bus.stats_clr = 1'b1;
    tick();
    bus.stats_clr = 1'b0;
    set_req(1, 64'd20, 64'd22, 8'hFF, 32'h500);
    bus.req_valid = 4'b0010;
    repeat (3) cyc_check(4'b0010, 1'b0, 1'b1);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("grant_cnt1", 64'(bus.grant_cnt[31:16]), EXP_CNT);
    chk("grant_cnt0", 64'(bus.grant_cnt[15:0]), 64'd0);
    tick();
    bus.stats_clr = 1'b1;
    bus.req_valid = 4'b0010;
    cyc_check(4'b0010, 1'b0, 1'b1);
    bus.stats_clr = 1'b0;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("grant_cnt_clr", bus.grant_cnt, 64'd0);
    tick();
    idle(5);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/valu_rr_sched.md
Name: valu_rr_sched

Overview:
- Round-robin scheduler that shares one fixed-latency vector ALU (vector add unit) among NUM_REQ requesters.
- Per requester: accepts operand requests over valid/ready, issues one op per cycle to the ALU, tracks which requester owns each in-flight op, and routes results back.
- Flush/drain FSM lets the pipeline controller quiesce the ALU before reconfiguration.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- VECTOR_WIDTH, 64, operand/result width in bits.
- VECTOR_BYTE, 8, byte-enable width.
- ADDR_WIDTH, 32, destination address width.
- ALU_LATENCY, 1, cycles from alu_valid to the result at the ALU output (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero.
- req_vec1  in  NUM_REQ*VECTOR_WIDTH  operand 1; requester i occupies slice i.
- req_vec2  in  NUM_REQ*VECTOR_WIDTH  operand 2, flattened the same way.
- req_byte_en  in  NUM_REQ*VECTOR_BYTE  byte enables, flattened.
- req_addr  in  NUM_REQ*ADDR_WIDTH  destination address, flattened.
- alu_valid  out  1  issue strobe to the ALU.
- alu_vec1 / alu_vec2  out  VECTOR_WIDTH  registered operands.
- alu_byte_en  out  VECTOR_BYTE  registered byte enables.
- alu_addr  out  ADDR_WIDTH  registered address.
- alu_out_vec  in  VECTOR_WIDTH  ALU result.
- alu_out_addr  in  ADDR_WIDTH  ALU result address.
- resp_valid  out  NUM_REQ  one-hot result strobe to the owning requester.
- resp_vec  out  VECTOR_WIDTH  result data.
- resp_addr  out  ADDR_WIDTH  result address.
- flush_req  in  1  request to drain the ALU.
- flush_done  out  1  one-cycle pulse when drained.
- grant_cnt  out  NUM_REQ*16  per-requester grant counters (see Optional Feature).
- stats_clr  in  1  clear grant_cnt.

Behaviour:
- Reset values:
  - req_ready=0 (no grants during reset).
  - alu_valid=0, alu_vec1/alu_vec2/alu_byte_en/alu_addr=0.
  - resp_valid=0, resp_vec/resp_addr=0, flush_done=0, grant_cnt=0.
  - RR pointer=0, tag pipe empty, FSM=RUN.
  - rst mid-operation discards all in-flight tags; no response is produced for them.
- Arbitration:
  - req_ready is combinational, asserted only in RUN.
  - Search starts at the RR pointer and wraps from NUM_REQ-1 to 0; the first set req_valid wins.
  - A handshake is req_valid[i]&req_ready[i]. After it, pointer=(i+1) mod NUM_REQ; with no grant, the pointer holds.
  - A requester must hold its valid and fields stable until granted.
- Issue:
  - Grant in cycle t gives alu_valid=1 in t+1, carrying the winner's slice of fields; alu_valid=0 otherwise.
  - Operand registers hold their last value when alu_valid=0.
- Zero-enable ops: if the granted req_byte_en[0]=0, the ALU ignores the op. The scheduler still issues and acks it, but enters no tag, so no response is ever produced.
- Tag pipe:
  - Shift register, depth ALU_LATENCY, entries {valid, id[$clog2(NUM_REQ)-1:0]}, loaded at issue.
  - A tag reaching the end of the pipe samples alu_out_vec/alu_out_addr.
  - The response is registered: resp_valid[id]=1 in cycle t+2+ALU_LATENCY (t+3 by default), with resp_vec/resp_addr.
  - Result validity is taken only from the tag pipe. The ALU's own output-valid is level-held, so it is not used.
  - Back-to-back grants yield back-to-back responses; no backpressure on responses.
- FSM:
  - RUN: grants allowed. On flush_req go to DRAIN; the same-cycle grant is suppressed because ready is gated by next state = RUN only.
  - DRAIN: no grants. Go to DONE when alu_valid=0, all tags are invalid, and no resp_valid is pending.
  - DONE: flush_done=1 for one cycle, then RUN.
  - flush_req is ignored outside RUN. If flush_req is held high, DONE returns to RUN and re-enters DRAIN next cycle.
  - Flush with an empty pipe: DRAIN lasts 1 cycle, then DONE.

Optional Feature:
- Macro: VALU_SCHED_STATS_EN.
- Defined:
  - grant_cnt slice i increments on each handshake of requester i and saturates at 16'hFFFF.
  - stats_clr zeroes all counters synchronously; a clear wins over a same-cycle increment.
- Undefined: grant_cnt is tied to 0, stats_clr is ignored, and no counter flops are built.

Test Plan:
- Single request: req_valid=4'b0100, vec1=5, vec2=7, byte_en=8'hFF, addr=0x40 at t → req_ready=4'b0100 at t, alu_valid at t+1, resp_valid=4'b0100 with resp_vec=12, resp_addr=0x40 at t+3.
- Fairness: all 4 requesters held valid 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; responses arrive in the same order, back-to-back.
- Wrap-around: pointer=3 with req_valid=4'b1001 → grant 3, then grant 0; all-ones operands (64'hFFFF_FFFF_FFFF_FFFF+1) → resp_vec=0.
- Flush: flush_req pulsed one cycle after 2 grants → no further req_ready; both responses delivered; flush_done pulses 1 cycle after the last resp_valid cycle's pipe is empty; grants resume next cycle.
- Corner cases: granted request with byte_en=8'hFE → acked with no resp_valid ever. rst asserted while 1 op is in flight → no response; all outputs are 0 the cycle after.
- With VALU_SCHED_STATS_EN: 3 grants to requester 1 → grant_cnt slice 1 = 3; stats_clr → 0.
